// File: rtl/chaotic_prng_pkg.sv
// Shared definitions for the chaotic PRNG stream.
// Contents: control register byte offsets, the sequencer state type,
// fixed-point widths for the logistic map, the saturation constant,
// and the N_BITS clamp helper.
package chaotic_prng_pkg;

  localparam logic [5:0] ADDR_CTRL     = 6'h00;
  localparam logic [5:0] ADDR_SEED     = 6'h10;
  localparam logic [5:0] ADDR_R        = 6'h18;
  localparam logic [5:0] ADDR_NBITS    = 6'h1C;
  localparam logic [5:0] ADDR_NUM_BITS = 6'h24;

  // x is Q0.32, r is Q3.29
  localparam int FRAC_W = 32;
  localparam int R_FRAC = 29;

  localparam logic [FRAC_W-1:0] X_SAT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_A,
    ST_MUL_B,
    ST_SHIFT,
    ST_EMIT,
    ST_DONE
  } state_t;

  // Bits extracted per iteration: 0 means 1, anything above max_n means max_n.
  function automatic logic [5:0] clamp_nbits(input logic [31:0] raw, input int unsigned max_n);
    if (raw == 32'd0) return 6'd1;
    if (raw > max_n) return 6'(max_n);
    return raw[5:0];
  endfunction

endpackage

// File: rtl/logistic_map_step.sv
// Two-stage logistic map datapath: x' = r * x * (1 - x).
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_load, i_seed  : load x from the seed (run start)
//   i_r             : growth rate, Q3.29
//   i_mul_a_en      : capture p = x*(1-x)
//   i_mul_b_en      : capture x = sat(r*p)
//   o_x             : current x, Q0.32
module logistic_map_step
  import chaotic_prng_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [FRAC_W-1:0] i_seed,
  input  logic [FRAC_W-1:0] i_r,
  input  logic              i_mul_a_en,
  input  logic              i_mul_b_en,
  output logic [FRAC_W-1:0] o_x
);

  localparam int PA_W = 2 * FRAC_W + 1;
  localparam int PB_W = 2 * FRAC_W;
  localparam int T_W  = FRAC_W + 3;

  logic [FRAC_W-1:0] r_x;
  logic [FRAC_W-1:0] r_p;
  logic [FRAC_W:0]   w_one_minus_x;
  logic [FRAC_W-1:0] w_p;
  logic [T_W-1:0]    w_t;
  logic [FRAC_W-1:0] w_x_sat;

  // 33-bit (1 - x) so that x = 0 gives exactly 1.0 instead of wrapping to 0
  assign w_one_minus_x = {1'b1, {FRAC_W{1'b0}}} - {1'b0, r_x};

  // x*(1-x) <= 0.25, so the top product bits above the kept 32 are always zero
  assign w_p = FRAC_W'(({{(PA_W-FRAC_W){1'b0}}, r_x}
                        * {{(PA_W-FRAC_W-1){1'b0}}, w_one_minus_x}) >> FRAC_W);

  assign w_t = T_W'(({{(PB_W-FRAC_W){1'b0}}, i_r}
                     * {{(PB_W-FRAC_W){1'b0}}, r_p}) >> R_FRAC);

  // r up to ~8 can push the result to 1.0 or beyond; clamp to the largest Q0.32
  assign w_x_sat = (|w_t[T_W-1:FRAC_W]) ? X_SAT : w_t[FRAC_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x <= '0;
      r_p <= '0;
    end else begin
      if (i_load)
        r_x <= i_seed;
      else if (i_mul_b_en)
        r_x <= w_x_sat;
      if (i_mul_a_en)
        r_p <= w_p;
    end
  end

  assign o_x = r_x;

endmodule

// File: rtl/chaotic_prng_stream.sv
// Chaotic PRNG stream: iterates a fixed-point logistic map and packs the
// low n_bits of every iterate into DATA_W-bit AXI-Stream beats.
// Ports:
//   ap_clk, ap_rst_n         : clock, asynchronous active-low reset
//   s_axi_control_*          : write-only register port (AW/W channels)
//   out_stream_TDATA/TVALID/TREADY/TLAST : packed random bit stream
//   ap_idle                  : high while idle
//   ap_done                  : one-cycle pulse when a run ends
module chaotic_prng_stream
  import chaotic_prng_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_NBITS = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              s_axi_control_AWVALID,
  output logic              s_axi_control_AWREADY,
  input  logic [5:0]        s_axi_control_AWADDR,
  input  logic              s_axi_control_WVALID,
  output logic              s_axi_control_WREADY,
  input  logic [31:0]       s_axi_control_WDATA,
  output logic [DATA_W-1:0] out_stream_TDATA,
  output logic              out_stream_TVALID,
  input  logic              out_stream_TREADY,
  output logic              out_stream_TLAST,
  output logic              ap_idle,
  output logic              ap_done
);

  localparam int IDX_W = $clog2(DATA_W);

  logic              r_wr_ack;
  logic              w_wr_fire;
  logic              w_start;
  logic [31:0]       r_seed;
  logic [31:0]       r_r;
  logic [31:0]       r_nbits_raw;
  logic [31:0]       r_num_bits;
  state_t            r_state;
  logic [31:0]       r_remain;
  logic [5:0]        r_iter_left;
  logic [4:0]        r_bit_idx;
  logic [DATA_W-1:0] r_acc;
  logic [IDX_W-1:0]  r_acc_cnt;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tvalid;
  logic              r_tlast;
  logic              r_done;
  logic              r_idle;
  logic [31:0]       w_x;
  logic [DATA_W-1:0] w_acc_next;
  logic              w_word_full;
  logic              w_last_bit;

  // Ready pulses one cycle, then the !r_wr_ack term forces a gap cycle
  assign w_wr_fire = r_wr_ack && s_axi_control_AWVALID && s_axi_control_WVALID;
  assign w_start   = w_wr_fire && (s_axi_control_AWADDR == ADDR_CTRL)
                     && s_axi_control_WDATA[0] && (r_state == ST_IDLE);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wr_ack    <= 1'b0;
      r_seed      <= '0;
      r_r         <= '0;
      r_nbits_raw <= '0;
      r_num_bits  <= '0;
    end else begin
      r_wr_ack <= s_axi_control_AWVALID && s_axi_control_WVALID && !r_wr_ack;
      // Configuration is frozen for the duration of a run
      if (w_wr_fire && (r_state == ST_IDLE)) begin
        unique case (s_axi_control_AWADDR)
          ADDR_SEED:     r_seed      <= s_axi_control_WDATA;
          ADDR_R:        r_r         <= s_axi_control_WDATA;
          ADDR_NBITS:    r_nbits_raw <= s_axi_control_WDATA;
          ADDR_NUM_BITS: r_num_bits  <= s_axi_control_WDATA;
          default: ;
        endcase
      end
    end
  end

  logistic_map_step u_step (
    .i_clk      (ap_clk),
    .i_rst_n    (ap_rst_n),
    .i_load     (w_start),
    .i_seed     (r_seed),
    .i_r        (r_r),
    .i_mul_a_en (r_state == ST_MUL_A),
    .i_mul_b_en (r_state == ST_MUL_B),
    .o_x        (w_x)
  );

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[r_acc_cnt] = w_x[r_bit_idx];
  end

  assign w_word_full = (r_acc_cnt == IDX_W'(DATA_W - 1));
  assign w_last_bit  = (r_remain == 32'd1);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state     <= ST_IDLE;
      r_remain    <= '0;
      r_iter_left <= '0;
      r_bit_idx   <= '0;
      r_acc       <= '0;
      r_acc_cnt   <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_done      <= 1'b0;
      r_idle      <= 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_remain  <= r_num_bits;
            r_acc     <= '0;
            r_acc_cnt <= '0;
            r_idle    <= 1'b0;
            if (r_num_bits == 32'd0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_MUL_A;
            end
          end
        end
        ST_MUL_A: r_state <= ST_MUL_B;
        ST_MUL_B: begin
          r_iter_left <= clamp_nbits(r_nbits_raw, MAX_NBITS);
          r_bit_idx   <= '0;
          r_state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_acc       <= w_acc_next;
          r_acc_cnt   <= r_acc_cnt + IDX_W'(1);
          r_bit_idx   <= r_bit_idx + 5'd1;
          r_iter_left <= r_iter_left - 6'd1;
          r_remain    <= r_remain - 32'd1;
          if (w_word_full || w_last_bit) begin
            r_state  <= ST_EMIT;
            r_tdata  <= w_acc_next;
            r_tvalid <= 1'b1;
            r_tlast  <= w_last_bit;
          end else if (r_iter_left == 6'd1) begin
            r_state <= ST_MUL_A;
          end
        end
        ST_EMIT: begin
          if (out_stream_TREADY) begin
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_acc     <= '0;
            r_acc_cnt <= '0;
            if (r_remain == 32'd0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (r_iter_left == 6'd0) begin
              r_state <= ST_MUL_A;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_idle  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axi_control_AWREADY = r_wr_ack;
  assign s_axi_control_WREADY  = r_wr_ack;
  assign out_stream_TDATA      = r_tdata;
  assign out_stream_TVALID     = r_tvalid;
  assign out_stream_TLAST      = r_tlast;
  assign ap_idle               = r_idle;
  assign ap_done               = r_done;

endmodule

// File: doc/chaotic_prng_stream.md
# chaotic_prng_stream

- Parametrised RTL successor to the HLS `prng_generator`.
- Iterates a fixed-point logistic map, x' = r·x·(1−x), from a programmable seed and growth rate.
- Extracts `n_bits` LSBs per iteration and packs them into `DATA_W`-bit AXI-Stream words; `TLAST` marks the final word after `num_bits` bits.
- Sits behind the same AXI-Lite-style control write port and feeds the downstream stream consumer (DMA/FIFO).

## Interface
- `DATA_W`, 8: stream word width; legal 8, 16, 32.
- `MAX_NBITS`, 16: upper clamp on bits extracted per iteration; ≤ 32.
- `ap_clk` in 1: single clock; all logic rising-edge.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `s_axi_control_AWVALID` in 1: write address valid.
- `s_axi_control_AWREADY` out 1: write address accepted.
- `s_axi_control_AWADDR` in 6: register byte offset.
- `s_axi_control_WVALID` in 1: write data valid.
- `s_axi_control_WREADY` out 1: write data accepted.
- `s_axi_control_WDATA` in 32: register write data.
- `out_stream_TDATA` out DATA_W: packed random bits; first bit in bit 0.
- `out_stream_TVALID` out 1: beat valid.
- `out_stream_TREADY` in 1: sink ready.
- `out_stream_TLAST` out 1: final beat of the run.
- `ap_idle` out 1: high in IDLE.
- `ap_done` out 1: one-cycle pulse at run end.

## Operation
- Registers:
  - 0x00 CTRL: bit0 = ap_start, write-1 pulse.
  - 0x10 SEED: Q0.32, unsigned.
  - 0x18 R: Q3.29; 4.0 = 0x8000_0000.
  - 0x1C N_BITS: 0 is treated as 1; values > MAX_NBITS clamp to MAX_NBITS.
  - 0x24 NUM_BITS: 32-bit total bits per run.
  - Other addresses: accepted and discarded.
- Write handshake: when AWVALID && WVALID, AWREADY = WREADY = 1 for exactly one cycle, then 0 for at least one cycle. Register updated on that edge.
- SEED/R/N_BITS/NUM_BITS writes while busy are accepted but ignored. ap_start while busy is ignored.
- Start: x loads SEED; bit counter loads NUM_BITS. NUM_BITS = 0 → ap_done pulse next cycle, no beat, back to IDLE.
- States:
  - IDLE → MUL_A on start.
  - MUL_A: p = (x·(2^32 − x)) >> 32. Use a 33-bit (1−x) so x = 0 is legal.
  - MUL_B: t = (R·p) >> 29 (35 bits); x = t saturated to 0xFFFF_FFFF.
  - SHIFT: one bit per cycle from x[0] upward into the word accumulator. Decrement the per-iteration count and the remaining-bits count.
  - EMIT when the accumulator holds DATA_W bits or remaining bits reach 0. Unfilled upper bits are zero.
  - EMIT: hold TVALID/TDATA/TLAST until TREADY. On handshake, go to SHIFT (iteration bits left), MUL_A (iteration exhausted), or DONE (remaining = 0).
  - DONE: ap_done = 1 for one cycle → IDLE.
- Beats per run = ceil(NUM_BITS / DATA_W). TLAST is 1 only on the last beat.
- A restart reloads SEED, so runs are reproducible.

## Timing
- Reset values: AWREADY = WREADY = 0, TVALID = 0, TLAST = 0, TDATA = 0, ap_done = 0, ap_idle = 1. All registers 0; state IDLE.
- Start to first MUL_A: 1 cycle after the CTRL write edge.
- Per iteration: 2 cycles + N_BITS cycles, plus EMIT stalls.
- EMIT with TREADY = 1: exactly 1 cycle.
- TDATA/TLAST stable while TVALID && !TREADY. TVALID never drops without a handshake, except on reset.
- ap_done asserts the cycle after the last handshake.
- Reset mid-run: outputs go to reset values asynchronously; no partial beat completes.

## Structure
- Package `chaotic_prng_pkg`:
  - Register offsets.
  - State enum.
  - Q-format widths (FRAC_W = 32, R_FRAC = 29).
  - Saturation constant.
- Sub-module `logistic_map_step`: two-stage multiply datapath with saturation, MUL_A/MUL_B enables. The FSM, packer and control regs stay in the top.

## Test plan
- SEED = 0xC000_0000, R = 0x8000_0000, N_BITS = 5, NUM_BITS = 100, DATA_W = 8, TREADY = 1 → fixed point 0.75; 13 beats, all 0x00, TLAST on beat 13 only, one ap_done pulse.
- SEED = 0x8000_0000, R = 0x8000_0000, N_BITS = 8, NUM_BITS = 24 → x saturates to 0xFFFF_FFFF, then 0. Beats: 0xFF, 0x00, 0x00.
- Same run with TREADY low for 5 cycles on beat 2 → TDATA/TLAST held stable, same 3 beats, no loss or duplication.
- NUM_BITS = 0 then start → no TVALID; ap_done pulse exactly once; ap_idle returns high.
- N_BITS write 0 → behaves as 1; write 40 → behaves as 16 (check beat count/content against a model). SEED write and second start mid-run → ignored, stream unchanged.
- ap_rst_n low during beat 5 of a 100-bit run → TVALID = 0 immediately, ap_idle = 1, registers cleared; fresh config and run completes normally.
